// File: rtl/dmem_access_unit.sv
// dmem_access_unit: memory-stage sequencer driving a byte-enabled synchronous data RAM.
// Loads stall the pipeline for the RAM read latency and return the full word.
// Stores issue in a single cycle with no stall.
// Ports:
//   clk, rst (async, active-high)
//   mem_r, mem_w       load / store request from the MEM stage
//   Addr_in            byte address
//   wea_mem            byte write enables
//   Data_write_to_dm   store data
//   Data_read_from_dm  captured RAM word
//   stall              freeze request to the pipeline
//   ram_en, ram_we, ram_addr, ram_din, ram_dout   RAM port
//   addr_fault         sticky out-of-range flag
//   stall_cycles       saturating count of stalled cycles
module dmem_access_unit #(
  parameter int ADDR_W = 10,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_r,
  input  logic              mem_w,
  input  logic [31:0]       Addr_in,
  input  logic [3:0]        wea_mem,
  input  logic [31:0]       Data_write_to_dm,
  output logic [31:0]       Data_read_from_dm,
  output logic              stall,
  output logic              ram_en,
  output logic [3:0]        ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_din,
  input  logic [31:0]       ram_dout,
  output logic              addr_fault,
  output logic [31:0]       stall_cycles
);
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  state_t state;
  logic [1:0] cnt;
  logic [31:0] rdata;
  logic in_range, idle, st, ld, unused_addr;
  assign in_range = Addr_in[31:ADDR_W+2] == '0;
  assign idle = ~rst & (state == IDLE);
  // a simultaneous load and store request is handled as a store
  assign st = idle & mem_w;
  assign ld = idle & mem_r & ~mem_w;
  assign ram_en = (st | ld) & in_range;
  assign ram_we = (st & in_range) ? wea_mem : 4'b0;
  assign ram_din = Data_write_to_dm;
  assign ram_addr = Addr_in[ADDR_W+1:2];
  assign stall = ~rst & ((state == WAIT) | ld);
  assign Data_read_from_dm = rdata;
  assign unused_addr = ^Addr_in[1:0];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      cnt <= 2'd0;
      rdata <= '0;
      addr_fault <= 1'b0;
      stall_cycles <= '0;
    end else begin
      if (stall && stall_cycles != '1) stall_cycles <= stall_cycles + 32'd1;
      if ((st | ld) && !in_range) addr_fault <= 1'b1;
      case (state)
        IDLE:
          if (ld) begin
            if (in_range) begin
              cnt <= 2'(READ_LAT - 1);
              state <= WAIT;
            end else begin
              rdata <= '0;
              state <= DONE;
            end
          end
        WAIT:
          if (cnt == 2'd0) begin
            rdata <= ram_dout;
            state <= DONE;
          end else cnt <= cnt - 2'd1;
        default: state <= IDLE;
      endcase
    end
endmodule
